imem_loader: RTL and testbench

Boot-time writer for the byte-addressed, little-endian instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles the bytes into 32-bit instruction words. It writes each word into the instruction memory write port at consecutive word-aligned addresses, starting at 0. The processor is held in reset until a complete image has loaded and its checksum has verified.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: turns a framed little-endian byte stream into 32-bit instruction
// memory writes and releases the processor once the payload checksum verifies.
module imem_loader #(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int MAX_WORDS = 2**24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [31:0] MAX_N = MAX_WORDS;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] count;    // header word count N
  logic [31:0] k;        // words written so far
  logic [1:0]  lane;     // byte position within the current header/word
  logic [7:0]  sum;
  logic [23:0] word_lo;  // lanes 0..2 of the word being assembled
  logic [31:0] hdr_full;
  logic        accept;
  logic        last_lane;
  logic        hdr_bad;

  // Handshake: a byte transfers on every rising edge where in_valid && in_ready.
  // in_ready is registered and depends only on the state, so the producer may
  // hold in_valid/in_data for any number of cycles; nothing is consumed while
  // in_ready is low.
  assign accept    = in_valid && in_ready;
  assign last_lane = (lane == 2'd3);
  assign hdr_full  = {in_data, count[31:8]};
  assign hdr_bad   = (hdr_full == 32'd0) || (hdr_full > MAX_N);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (accept && last_lane) state_nxt = hdr_bad ? S_ERROR : S_LOAD;
      end
      S_LOAD: begin
        if (accept && last_lane && (k == count - 32'd1)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_nxt = (in_data == sum) ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
      count     <= '0;
      k         <= '0;
      lane      <= '0;
      sum       <= '0;
      word_lo   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_HDR) || (state_nxt == S_LOAD) || (state_nxt == S_CSUM);
      busy     <= (state_nxt == S_HDR) || (state_nxt == S_LOAD) || (state_nxt == S_CSUM);
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERROR);
      cpu_hold <= (state_nxt != S_DONE);
      mem_we   <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            count <= '0;
            k     <= '0;
            lane  <= '0;
            sum   <= '0;
          end
        end
        S_HDR: begin
          if (accept) begin
            count <= hdr_full;
            lane  <= lane + 2'd1;
            if (last_lane) begin
              k   <= '0;
              sum <= '0;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            sum     <= sum + in_data;
            lane    <= lane + 2'd1;
            word_lo <= {in_data, word_lo[23:8]};
            if (last_lane) begin
              mem_we    <= 1'b1;
              mem_addr  <= AWIDTH'(k << 2);
              mem_wdata <= DWIDTH'({in_data, word_lo});
              k         <= k + 32'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from word lists,
// expected writes and outcomes come from a frame-level model.
module tb_imem_loader;

  localparam int MAX_WORDS = 2**24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];        // {byte address, word}
  logic [31:0] frame_words[$];  // payload of the next frame

  imem_loader #(.AWIDTH(32), .DWIDTH(32), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          fails++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks (all called at posedge + 1)
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int guard;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_outputs",
          {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold},
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  // Frame-level reference: header N, payload from frame_words, checksum = byte
  // sum mod 256 (plus one when bad). rst_after >= 0 aborts before that payload byte.
  task automatic run_frame(input logic [31:0] n, input bit bad, input int max_gap,
                           input int rst_after, input bit inject_start);
    bit          hdr_err;
    int          csum;
    logic [7:0]  b;
    longint      nbytes;
    hdr_err = (n == 0) || (n > MAX_WORDS);
    pulse_start();
    check("hdr_entry {busy,in_ready,cpu_hold,done,error}",
          {busy, in_ready, cpu_hold, done, error}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int j = 0; j < 4; j++) send_byte(8'((n >> (8 * j)) & 32'hFF), max_gap);
    if (hdr_err) begin
      check("hdr_error {done,error,cpu_hold,in_ready,busy}",
            {done, error, cpu_hold, in_ready, busy}, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      return;
    end
    check("hdr_accept {in_ready,error,busy}", {in_ready, error, busy}, {1'b1, 1'b0, 1'b1});
    csum   = 0;
    nbytes = longint'(n) * 4;
    for (longint i = 0; i < nbytes; i++) begin
      if (rst_after == i) begin
        pulse_rst();
        return;
      end
      if (inject_start && i == 2) begin
        pulse_start();
        check("start_ignored {busy,in_ready,cpu_hold}", {busy, in_ready, cpu_hold},
              {1'b1, 1'b1, 1'b1});
      end
      b    = 8'((frame_words[i / 4] >> (8 * (i % 4))) & 32'hFF);
      csum = (csum + b) % 256;
      if (i % 4 == 3) exp_q.push_back({32'(4 * (i / 4)), frame_words[i / 4]});
      send_byte(b, max_gap);
      if (i % 4 == 3)
        check("write_latency {mem_we,in_ready}", {mem_we, in_ready}, {1'b1, 1'b1});
    end
    if (bad) csum = (csum + 1) % 256;
    send_byte(8'(csum), max_gap);
    check("result {done,error,cpu_hold,in_ready,busy}",
          {done, error, cpu_hold, in_ready, busy},
          {!bad, bad, bad, 1'b0, 1'b0});
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_two_word();
    frame_words = {32'h0041E5B3, 32'h00208433};
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold},
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    @(posedge clk); #1;

    // fixed two-word image, good then bad checksum
    set_two_word();
    run_frame(32'd2, 1'b0, 0, -1, 1'b0);
    set_two_word();
    run_frame(32'd2, 1'b1, 0, -1, 1'b0);

    // header boundaries
    frame_words = {};
    run_frame(32'd0, 1'b0, 0, -1, 1'b0);
    run_frame(32'h01000001, 1'b0, 0, -1, 1'b0);
    run_frame(32'h01000000, 1'b0, 0, 0, 1'b0);

    // gaps plus ignored start during LOAD
    set_two_word();
    run_frame(32'd2, 1'b0, 5, -1, 1'b1);

    // reset after the 6th payload byte, then a full load
    set_two_word();
    run_frame(32'd2, 1'b0, 0, 6, 1'b0);
    check("abort_writes_drained", 64'(exp_q.size()), 64'd0);
    set_two_word();
    run_frame(32'd2, 1'b0, 0, -1, 1'b0);

    // back-to-back one-word load after DONE
    frame_words = {32'h00120093};
    run_frame(32'd1, 1'b0, 0, -1, 1'b0);

    // random frames
    for (int f = 0; f < 10; f++) begin
      int nw;
      nw = $urandom_range(1, 6);
      frame_words = {};
      for (int w = 0; w < nw; w++) frame_words.push_back($urandom);
      run_frame(32'(nw), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), -1,
                ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
